// File: rtl/regfile_access_sequencer_pkg.sv
// regfile_seq_pkg: shared types and constants for the register-file access
// sequencer.
//   state_e             - sequencer state encoding
//   *_LSB / *_BIT       - field positions inside an ARM data-processing word
//   OP_TST..OP_CMN      - compare-class opcodes (no register write-back)
//   COND_NV, PC_REG     - "never" condition code and the R15 register index
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int COND_LSB = 28;
  localparam int I_BIT    = 25;
  localparam int OPC_LSB  = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RM_LSB   = 0;

  localparam logic [3:0] OP_TST  = 4'b1000;
  localparam logic [3:0] OP_TEQ  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_CMN  = 4'b1011;

  localparam logic [3:0] COND_NV = 4'hF;
  localparam logic [3:0] PC_REG  = 4'hF;

endpackage

// File: rtl/regfile_access_sequencer_if.sv
// regfile_access_sequencer_if: instruction handshake plus register-file
// control bundle.
//   master : instruction source (drives IR/IR_VALID, observes the rest)
//   slave  : the sequencer (accepts IR, drives select/enable/strobes)
interface regfile_access_sequencer_if;
  logic [31:0] IR;
  logic        IR_VALID;
  logic        IR_READY;
  logic [3:0]  RA;
  logic [3:0]  RB;
  logic [3:0]  RC;
  logic        RFE;
  logic        OP_LATCH;
  logic        IMM_SEL;
  logic        SET_FLAGS;
  logic        PC_WRITE;
  logic        INSTR_DONE;

  modport master (
    output IR, IR_VALID,
    input  IR_READY, RA, RB, RC, RFE, OP_LATCH, IMM_SEL, SET_FLAGS,
           PC_WRITE, INSTR_DONE
  );

  modport slave (
    input  IR, IR_VALID,
    output IR_READY, RA, RB, RC, RFE, OP_LATCH, IMM_SEL, SET_FLAGS,
           PC_WRITE, INSTR_DONE
  );
endinterface

// File: rtl/regfile_access_sequencer_dp_field_decode.sv
// dp_field_decode: combinational field extraction for a data-processing word.
//   ir            in  : instruction word
//   rn, rd, rm    out : first operand, destination and second operand regs
//   i_bit, s_bit  out : immediate-operand flag and set-flags flag
//   no_writeback  out : compare-class opcode (TST/TEQ/CMP/CMN)
//   is_nv         out : condition field is "never"
module dp_field_decode
  import regfile_seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic        i_bit,
  output logic        s_bit,
  output logic        no_writeback,
  output logic        is_nv
);

  logic [3:0] opcode;
  logic [3:0] cond;

  // Bits 27:26 and the shifter field are irrelevant to sequencing.
  logic unused_bits;
  assign unused_bits = ^{ir[27:26], ir[11:4]};

  assign cond   = ir[COND_LSB +: 4];
  assign opcode = ir[OPC_LSB +: 4];
  assign rn     = ir[RN_LSB +: 4];
  assign rd     = ir[RD_LSB +: 4];
  assign rm     = ir[RM_LSB +: 4];
  assign i_bit  = ir[I_BIT];
  assign s_bit  = ir[S_BIT];
  assign is_nv  = (cond == COND_NV);

  assign no_writeback = (opcode == OP_TST) || (opcode == OP_TEQ) ||
                        (opcode == OP_CMP) || (opcode == OP_CMN);

endmodule

// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: sequences register-file reads, operand latch,
// execute wait and write-back for one data-processing instruction at a time.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : slave side of regfile_access_sequencer_if
//   EXEC_CYCLES: cycles spent in EXEC (1..15)
//
// state | meaning
// IDLE  | ready for a new instruction
// READ  | RA/RB selects driven from Rn/Rm
// LATCH | selects held, OP_LATCH strobe
// EXEC  | fixed execute window, down-counter to zero
// WRITE | RC=Rd with RFE low for one cycle
// DONE  | INSTR_DONE strobe
module regfile_access_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input logic                        CLK,
  input logic                        RST_N,
  regfile_access_sequencer_if.slave  bus
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        ir_ready_q, ir_ready_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [3:0]  rc_q, rc_d;
  logic        rfe_q, rfe_d;
  logic        op_latch_q, op_latch_d;
  logic        imm_sel_q, imm_sel_d;
  logic        set_flags_q, set_flags_d;
  logic        pc_write_q, pc_write_d;
  logic        done_q, done_d;

  logic [3:0]  rn, rd, rm;
  logic        i_bit, s_bit, no_writeback, is_nv;
  logic        in_op;

  // Decoding the next-state IR lets the IDLE capture decision (NV skip) and
  // all registered outputs come from one decoder instance.
  dp_field_decode u_decode (
    .ir           (ir_d),
    .rn           (rn),
    .rd           (rd),
    .rm           (rm),
    .i_bit        (i_bit),
    .s_bit        (s_bit),
    .no_writeback (no_writeback),
    .is_nv        (is_nv)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.IR_VALID) begin
          ir_d    = bus.IR;
          state_d = is_nv ? ST_DONE : ST_READ;
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: begin
        cnt_d   = EXEC_LOAD;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = no_writeback ? ST_DONE : ST_WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered value lines
  // up with the state it belongs to.
  always_comb begin
    in_op       = (state_d == ST_READ) || (state_d == ST_LATCH) ||
                  (state_d == ST_EXEC) || (state_d == ST_WRITE);
    ir_ready_d  = (state_d == ST_IDLE);
    ra_d        = in_op ? rn : 4'd0;
    rb_d        = (in_op && !i_bit) ? rm : 4'd0;
    imm_sel_d   = in_op && i_bit;
    set_flags_d = (state_d != ST_IDLE) && s_bit && !is_nv;
    op_latch_d  = (state_d == ST_LATCH);
    rc_d        = (state_d == ST_WRITE) ? rd : 4'd0;
    rfe_d       = (state_d != ST_WRITE);
    pc_write_d  = (state_d == ST_WRITE) && (rd == PC_REG);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      cnt_q       <= '0;
      ir_ready_q  <= 1'b1;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      rfe_q       <= 1'b1;
      op_latch_q  <= 1'b0;
      imm_sel_q   <= 1'b0;
      set_flags_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      ir_ready_q  <= ir_ready_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      rfe_q       <= rfe_d;
      op_latch_q  <= op_latch_d;
      imm_sel_q   <= imm_sel_d;
      set_flags_q <= set_flags_d;
      pc_write_q  <= pc_write_d;
      done_q      <= done_d;
    end
  end

  assign bus.IR_READY   = ir_ready_q;
  assign bus.RA         = ra_q;
  assign bus.RB         = rb_q;
  assign bus.RC         = rc_q;
  assign bus.RFE        = rfe_q;
  assign bus.OP_LATCH   = op_latch_q;
  assign bus.IMM_SEL    = imm_sel_q;
  assign bus.SET_FLAGS  = set_flags_q;
  assign bus.PC_WRITE   = pc_write_q;
  assign bus.INSTR_DONE = done_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb_regfile_access_sequencer: drives the same instruction stream into two
// sequencers (EXEC_CYCLES=1 and 4) and checks each against a cycle model and
// a completion scoreboard.
module tb_regfile_access_sequencer;

  typedef struct packed {
    logic       ir_ready;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       rfe;
    logic       op_latch;
    logic       imm_sel;
    logic       set_flags;
    logic       pc_write;
    logic       instr_done;
  } obs_t;

  typedef struct {
    int lat;
    int wr;
  } sb_t;

  localparam logic [31:0] W_ADD  = 32'hE0813002;
  localparam logic [31:0] W_CMP  = 32'hE1510002;
  localparam logic [31:0] W_IMM  = 32'hE2814005;
  localparam logic [31:0] W_PC   = 32'hE081F002;
  localparam logic [31:0] W_NV   = 32'hF0813002;
  localparam logic [31:0] W_TSTS = 32'hE1110002;
  localparam logic [31:0] W_ADDS = 32'hE0965007;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        ir_valid;

  int total = 0;
  int bad   = 0;

  sb_t q1[$];
  sb_t q4[$];

  // Observations from the EXEC_CYCLES=1 instance during the last run_instr.
  logic [3:0] rec_ra, rec_rb, rec_rc;
  logic       rec_imm, rec_sf, rec_pc;
  int         rec_latch, rec_rfe_low, rec_done;

  always #5 clk = ~clk;

  regfile_access_sequencer_if bus1 ();
  regfile_access_sequencer_if bus4 ();

  assign bus1.IR       = ir;
  assign bus1.IR_VALID = ir_valid;
  assign bus4.IR       = ir;
  assign bus4.IR_VALID = ir_valid;

  regfile_access_sequencer #(.EXEC_CYCLES(1)) dut1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus1)
  );

  regfile_access_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus4)
  );

  obs_t obs1, obs4;
  assign obs1 = {bus1.IR_READY, bus1.RA, bus1.RB, bus1.RC, bus1.RFE, bus1.OP_LATCH,
                 bus1.IMM_SEL, bus1.SET_FLAGS, bus1.PC_WRITE, bus1.INSTR_DONE};
  assign obs4 = {bus4.IR_READY, bus4.RA, bus4.RB, bus4.RC, bus4.RFE, bus4.OP_LATCH,
                 bus4.IMM_SEL, bus4.SET_FLAGS, bus4.PC_WRITE, bus4.INSTR_DONE};

  function automatic bit is_cmp_class(input logic [31:0] w);
    logic [3:0] opc;
    opc = w[24:21];
    return (opc >= 4'b1000) && (opc <= 4'b1011);
  endfunction

  // Cycle index (1 = first cycle after the accept edge) in which INSTR_DONE is high.
  function automatic int done_cycle(input logic [31:0] w, input int n);
    if (w[31:28] == 4'hF) return 1;
    if (is_cmp_class(w))  return n + 3;
    return n + 4;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ir_ready = 1'b1;
    o.rfe      = 1'b1;
    return o;
  endfunction

  // Expected outputs for cycle c, with a mask of the fields defined in that cycle.
  function automatic void model(input logic [31:0] w, input int n, input int c,
                                 output obs_t e, output obs_t m);
    int  last;
    bit  nv, imm, sf;
    logic [3:0] rn, rd, rm;
    nv  = (w[31:28] == 4'hF);
    imm = w[25];
    sf  = w[20];
    rn  = w[19:16];
    rd  = w[15:12];
    rm  = w[3:0];
    last = done_cycle(w, n);
    e = '0;
    e.rfe = 1'b1;
    m = '0;
    m.ir_ready = 1'b1;
    m.rfe = 1'b1;
    m.op_latch = 1'b1;
    m.pc_write = 1'b1;
    m.instr_done = 1'b1;
    if (c > last) begin
      e.ir_ready = 1'b1;
    end else if (c == last) begin
      e.instr_done = 1'b1;
      if (!nv) begin
        m.set_flags = 1'b1;
        e.set_flags = sf;
      end
    end else begin
      m.set_flags = 1'b1;
      e.set_flags = sf;
      if (c == 1) begin
        m.ra = 4'hF; m.rb = 4'hF; m.imm_sel = 1'b1;
        e.ra = rn;   e.rb = imm ? 4'd0 : rm; e.imm_sel = imm;
      end else if (c == 2) begin
        m.ra = 4'hF; m.rb = 4'hF;
        e.ra = rn;   e.rb = imm ? 4'd0 : rm;
        e.op_latch = 1'b1;
      end else if (c == n + 3) begin
        m.rc = 4'hF;
        e.rc = rd;
        e.rfe = 1'b0;
        e.pc_write = (rd == 4'hF);
      end
    end
  endfunction

  task automatic run_instr(input logic [31:0] w, input bit hold);
    obs_t e, m;
    int   stop, low1, low4;
    sb_t  s;
    stop = ((done_cycle(w, 1) > done_cycle(w, 4)) ? done_cycle(w, 1) : done_cycle(w, 4)) + 1;
    rec_ra = 'x; rec_rb = 'x; rec_rc = 4'd0; rec_imm = 1'bx; rec_sf = 1'bx; rec_pc = 1'b0;
    rec_latch = 0; rec_rfe_low = 0; rec_done = -1;
    low1 = 0; low4 = 0;
    @(negedge clk);
    total++;
    if (obs1.ir_ready !== 1'b1 || obs4.ir_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready w=%h got n1=%b n4=%b want 1", w, obs1.ir_ready, obs4.ir_ready);
    end
    ir = w;
    ir_valid = 1'b1;
    q1.push_back('{lat: done_cycle(w, 1), wr: (w[31:28] == 4'hF || is_cmp_class(w)) ? 0 : 1});
    q4.push_back('{lat: done_cycle(w, 4), wr: (w[31:28] == 4'hF || is_cmp_class(w)) ? 0 : 1});
    @(posedge clk);
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      model(w, 1, c, e, m);
      total++;
      if ((obs1 & m) !== (e & m)) begin
        bad++;
        $display("FAIL cycle_n1 w=%h c=%0d got=%h want=%h mask=%h", w, c, obs1, e, m);
      end
      model(w, 4, c, e, m);
      total++;
      if ((obs4 & m) !== (e & m)) begin
        bad++;
        $display("FAIL cycle_n4 w=%h c=%0d got=%h want=%h mask=%h", w, c, obs4, e, m);
      end
      if (c == 1) begin
        rec_ra = obs1.ra; rec_rb = obs1.rb; rec_imm = obs1.imm_sel; rec_sf = obs1.set_flags;
      end
      if (obs1.op_latch === 1'b1) rec_latch++;
      if (obs1.rfe === 1'b0) begin
        rec_rfe_low++; rec_rc = obs1.rc; rec_pc = obs1.pc_write; low1++;
      end
      if (obs4.rfe === 1'b0) low4++;
      if (obs1.instr_done === 1'b1) begin
        rec_done = c;
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sb_n1_extra_done c=%0d got done want none", c);
        end else begin
          s = q1.pop_front();
          if (s.lat != c || s.wr != low1) begin
            bad++;
            $display("FAIL sb_n1 w=%h got lat=%0d wr=%0d want lat=%0d wr=%0d", w, c, low1, s.lat, s.wr);
          end
        end
      end
      if (obs4.instr_done === 1'b1) begin
        total++;
        if (q4.size() == 0) begin
          bad++;
          $display("FAIL sb_n4_extra_done c=%0d got done want none", c);
        end else begin
          s = q4.pop_front();
          if (s.lat != c || s.wr != low4) begin
            bad++;
            $display("FAIL sb_n4 w=%h got lat=%0d wr=%0d want lat=%0d wr=%0d", w, c, low4, s.lat, s.wr);
          end
        end
      end
      if (!hold || obs1.instr_done === 1'b1 || obs4.instr_done === 1'b1) ir_valid = 1'b0;
    end
    ir_valid = 1'b0;
    total++;
    if (q1.size() != 0 || q4.size() != 0) begin
      bad++;
      $display("FAIL sb_timeout w=%h got pending n1=%0d n4=%0d want 0", w, q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir = '0;
    ir_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs1 !== idle_obs() || obs4 !== idle_obs()) begin
      bad++;
      $display("FAIL reset_hold got n1=%h n4=%h want %h", obs1, obs4, idle_obs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs1 !== idle_obs() || obs4 !== idle_obs()) begin
      bad++;
      $display("FAIL reset_release got n1=%h n4=%h want %h", obs1, obs4, idle_obs());
    end
  endtask

  task automatic test_add();
    run_instr(W_ADD, 1'b0);
    total++;
    if (rec_ra !== 4'd1 || rec_rb !== 4'd2 || rec_latch != 1 || rec_rc !== 4'd3 ||
        rec_pc !== 1'b0 || rec_done != 5) begin
      bad++;
      $display("FAIL add got ra=%h rb=%h latch=%0d rc=%h pc=%b done=%0d want 1 2 1 3 0 5",
               rec_ra, rec_rb, rec_latch, rec_rc, rec_pc, rec_done);
    end
  endtask

  task automatic test_cmp();
    run_instr(W_CMP, 1'b0);
    total++;
    if (rec_sf !== 1'b1 || rec_latch != 1 || rec_rfe_low != 0 || rec_done != 4) begin
      bad++;
      $display("FAIL cmp got sf=%b latch=%0d rfe_low=%0d done=%0d want 1 1 0 4",
               rec_sf, rec_latch, rec_rfe_low, rec_done);
    end
  endtask

  task automatic test_immediate();
    run_instr(W_IMM, 1'b0);
    total++;
    if (rec_imm !== 1'b1 || rec_rb !== 4'd0 || rec_rc !== 4'd4) begin
      bad++;
      $display("FAIL immediate got imm=%b rb=%h rc=%h want 1 0 4", rec_imm, rec_rb, rec_rc);
    end
  endtask

  task automatic test_pc_target();
    run_instr(W_PC, 1'b0);
    total++;
    if (rec_rc !== 4'hF || rec_pc !== 1'b1 || rec_rfe_low != 1) begin
      bad++;
      $display("FAIL pc_target got rc=%h pc=%b rfe_low=%0d want f 1 1", rec_rc, rec_pc, rec_rfe_low);
    end
  endtask

  task automatic test_nv();
    run_instr(W_NV, 1'b0);
    total++;
    if (rec_latch != 0 || rec_rfe_low != 0 || rec_done != 1) begin
      bad++;
      $display("FAIL nv got latch=%0d rfe_low=%0d done=%0d want 0 0 1", rec_latch, rec_rfe_low, rec_done);
    end
  endtask

  task automatic test_ignored_valid();
    run_instr(W_ADD, 1'b1);
    total++;
    if (rec_latch != 1 || rec_done != 5 || rec_rfe_low != 1) begin
      bad++;
      $display("FAIL ignored_valid got latch=%0d done=%0d rfe_low=%0d want 1 5 1", rec_latch, rec_done, rec_rfe_low);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(W_TSTS, 1'b0);
    total++;
    if (rec_sf !== 1'b1 || rec_rfe_low != 0) begin
      bad++;
      $display("FAIL b2b_tst got sf=%b rfe_low=%0d want 1 0", rec_sf, rec_rfe_low);
    end
    run_instr(W_ADDS, 1'b0);
    total++;
    if (rec_ra !== 4'd6 || rec_rb !== 4'd7 || rec_rc !== 4'd5 || rec_sf !== 1'b1) begin
      bad++;
      $display("FAIL b2b_adds got ra=%h rb=%h rc=%h sf=%b want 6 7 5 1", rec_ra, rec_rb, rec_rc, rec_sf);
    end
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    ir = W_ADD;
    ir_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ir_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs4.ir_ready !== 1'b0 || obs4.rfe !== 1'b1) begin
      bad++;
      $display("FAIL midop_busy got ready=%b rfe=%b want 0 1", obs4.ir_ready, obs4.rfe);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (obs1 !== idle_obs() || obs4 !== idle_obs()) begin
      bad++;
      $display("FAIL midop_reset got n1=%h n4=%h want %h", obs1, obs4, idle_obs());
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (obs1.instr_done !== 1'b0 || obs1.rfe !== 1'b1 ||
          obs4.instr_done !== 1'b0 || obs4.rfe !== 1'b1) begin
        bad++;
        $display("FAIL midop_after k=%0d got n1=%h n4=%h want done=0 rfe=1", k, obs1, obs4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_immediate();
    test_pc_target();
    test_nv();
    test_ignored_valid();
    test_back_to_back();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
